fpnew_opgroup_sharer: RTL and testbench



---
 rtl/fpnew_pkg.sv | 32 +++
 rtl/fpnew_credit_counter.sv | 43 ++++
 rtl/fpnew_opgroup_sharer.sv | 142 ++++++++++++++
 tb/tb_fpnew_opgroup_sharer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_pkg.sv
// Shared types and helpers for the opgroup sharer: configuration record, arbiter
// state encoding and the round-robin pick function.
package fpnew_pkg;

    typedef struct packed {
        int unsigned num_req;
        int unsigned max_outstanding;
    } sharer_cfg_t;

    localparam sharer_cfg_t DefaultSharerCfg = '{num_req: 4, max_outstanding: 4};

    localparam int unsigned RrMaxReq   = 32;
    localparam int unsigned RrIdxWidth = $clog2(RrMaxReq);

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    // First set bit of mask at or after ptr, wrapping; returns ptr when mask is empty.
    // Unused upper mask bits must be zero, so wrapping at RrMaxReq matches wrapping at NumReq.
    function automatic int unsigned rr_next(input int unsigned ptr,
                                            input logic [RrMaxReq-1:0] mask);
        logic [RrIdxWidth-1:0] idx;
        rr_next = ptr;
        for (int unsigned k = RrMaxReq; k > 0; k--) begin
            idx = RrIdxWidth'((ptr + k - 1) % RrMaxReq);
            if (mask[idx]) rr_next = 32'(idx);
        end
    endfunction

endpackage

// File: rtl/fpnew_credit_counter.sv
// Per-requester outstanding-operation counter; saturation is the caller's
// responsibility and is flagged as an error in simulation.
module fpnew_credit_counter #(
    parameter int unsigned MaxOutstanding = 4,
    localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    input  logic                dec_i,
    input  logic                clr_i,
    output logic [CntWidth-1:0] count_o,
    output logic                full_o
);

    logic [CntWidth-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !dec_i) begin
            count_d = count_q + CntWidth'(1);
        end else if (dec_i && !inc_i) begin
            count_d = count_q - CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = (count_q == CntWidth'(MaxOutstanding));

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(inc_i && !dec_i && !clr_i && full_o));

endmodule

// File: rtl/fpnew_opgroup_sharer.sv
// Shares one FPU opgroup between NumReq requesters: credit-gated round-robin
// issue with the requester index as tag, responses steered back by tag.
module fpnew_opgroup_sharer
    import fpnew_pkg::*;
#(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter type         ReqDataType    = logic,
    parameter type         RspDataType    = logic,
    localparam int unsigned IdxWidth      = $clog2(NumReq),
    localparam int unsigned CntWidth      = $clog2(MaxOutstanding + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic [NumReq-1:0]   req_valid_i,
    output logic [NumReq-1:0]   req_ready_o,
    input  ReqDataType          req_data_i [NumReq],
    output logic                fpu_valid_o,
    input  logic                fpu_ready_i,
    output ReqDataType          fpu_data_o,
    output logic [IdxWidth-1:0] fpu_tag_o,
    input  logic                fpu_rsp_valid_i,
    output logic                fpu_rsp_ready_o,
    input  RspDataType          fpu_rsp_data_i,
    input  logic [IdxWidth-1:0] fpu_rsp_tag_i,
    output logic [NumReq-1:0]   rsp_valid_o,
    input  logic [NumReq-1:0]   rsp_ready_i,
    output RspDataType          rsp_data_o,
    output logic                busy_o
);

    arb_state_e          state_d, state_q;
    logic [IdxWidth-1:0] lock_idx_d, lock_idx_q;
    logic [IdxWidth-1:0] rr_ptr_d, rr_ptr_q;
    logic [IdxWidth-1:0] grant_idx;
    logic [NumReq-1:0]   eligible, full, inc, dec;
    logic [CntWidth-1:0] cnt [NumReq];
    logic                issue_hs, rsp_hs, tag_ok;

    for (genvar g = 0; g < NumReq; g++) begin : gen_cnt
        fpnew_credit_counter #(
            .MaxOutstanding(MaxOutstanding)
        ) i_cnt (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .inc_i  (inc[g]),
            .dec_i  (dec[g]),
            .clr_i  (flush_i),
            .count_o(cnt[g]),
            .full_o (full[g])
        );
    end

    assign eligible = req_valid_i & ~full;
    assign tag_ok   = 32'(fpu_rsp_tag_i) < NumReq;

    // Issue side: a locked grant ignores eligibility so the offered beat stays stable.
    always_comb begin
        if (state_q == ARB_LOCKED) begin
            grant_idx = lock_idx_q;
        end else begin
            grant_idx = IdxWidth'(rr_next(32'(rr_ptr_q), RrMaxReq'(eligible)));
        end
        fpu_valid_o = !rst_i && !flush_i && ((state_q == ARB_LOCKED) || (|eligible));
        issue_hs    = fpu_valid_o && fpu_ready_i;
        fpu_data_o  = req_data_i[grant_idx];
        fpu_tag_o   = grant_idx;
        req_ready_o = '0;
        if (issue_hs) req_ready_o[grant_idx] = 1'b1;
    end

    // Response side: flush drains the opgroup output without delivering it.
    always_comb begin
        rsp_valid_o     = '0;
        fpu_rsp_ready_o = 1'b0;
        rsp_data_o      = fpu_rsp_data_i;
        if (rst_i) begin
            fpu_rsp_ready_o = 1'b0;
        end else if (flush_i) begin
            fpu_rsp_ready_o = 1'b1;
        end else if (tag_ok) begin
            rsp_valid_o[fpu_rsp_tag_i] = fpu_rsp_valid_i;
            fpu_rsp_ready_o            = rsp_ready_i[fpu_rsp_tag_i];
        end
        rsp_hs = fpu_rsp_valid_i && fpu_rsp_ready_o && !flush_i;
    end

    always_comb begin
        busy_o = 1'b0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            inc[i] = issue_hs && (grant_idx == IdxWidth'(i));
            dec[i] = rsp_hs && (fpu_rsp_tag_i == IdxWidth'(i));
            if (cnt[i] != '0) busy_o = 1'b1;
        end
        if (rst_i) busy_o = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (flush_i) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = '0;
        end else begin
            if (issue_hs) begin
                rr_ptr_d = (32'(grant_idx) == NumReq - 1) ? '0 : grant_idx + IdxWidth'(1);
            end
            case (state_q)
                ARB_IDLE: begin
                    if (fpu_valid_o && !fpu_ready_i) begin
                        state_d    = ARB_LOCKED;
                        lock_idx_d = grant_idx;
                    end
                end
                ARB_LOCKED: begin
                    if (fpu_ready_i) state_d = ARB_IDLE;
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ARB_IDLE;
            lock_idx_q <= '0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    a_rsp_tag_range: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        fpu_rsp_valid_i |-> tag_ok);
    a_rsp_has_credit: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        (fpu_rsp_valid_i && fpu_rsp_ready_o && tag_ok) |-> (cnt[fpu_rsp_tag_i] != '0));

endmodule

// File: tb/tb_fpnew_opgroup_sharer.sv
// Scoreboard bench for fpnew_opgroup_sharer: stimulus pushes expected issues and
// responses, a negedge monitor pops and compares them; state checks are inline.
module tb_fpnew_opgroup_sharer;

    localparam int unsigned NumReq = 4;
    localparam int unsigned MaxOut = 3;

    typedef logic [15:0] data_t;
    typedef struct { logic [1:0] tag; data_t data; } iss_t;
    typedef struct { logic [3:0] vec; data_t data; logic rdy; } rsp_t;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [3:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    data_t       req_data [NumReq];
    logic        fpu_valid, fpu_ready, fpu_rsp_valid, fpu_rsp_ready, busy;
    data_t       fpu_data, fpu_rsp_data, rsp_data;
    logic [1:0]  fpu_tag, fpu_rsp_tag;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    fpnew_opgroup_sharer #(
        .NumReq        (NumReq),
        .MaxOutstanding(MaxOut),
        .ReqDataType   (data_t),
        .RspDataType   (data_t)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_data_i     (req_data),
        .fpu_valid_o    (fpu_valid),
        .fpu_ready_i    (fpu_ready),
        .fpu_data_o     (fpu_data),
        .fpu_tag_o      (fpu_tag),
        .fpu_rsp_valid_i(fpu_rsp_valid),
        .fpu_rsp_ready_o(fpu_rsp_ready),
        .fpu_rsp_data_i (fpu_rsp_data),
        .fpu_rsp_tag_i  (fpu_rsp_tag),
        .rsp_valid_o    (rsp_valid),
        .rsp_ready_i    (rsp_ready),
        .rsp_data_o     (rsp_data),
        .busy_o         (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic push_iss(input logic [1:0] tag);
        iss_t e;
        e.tag  = tag;
        e.data = req_data[tag];
        iss_q.push_back(e);
    endtask

    task automatic push_rsp(input logic rdy);
        rsp_t e;
        logic [3:0] one;
        one    = 4'b0001;
        e.vec  = one << fpu_rsp_tag;
        e.data = fpu_rsp_data;
        e.rdy  = rdy;
        rsp_q.push_back(e);
    endtask

    task automatic drive_rsp(input logic [1:0] tag);
        fpu_rsp_valid = 1'b1;
        fpu_rsp_tag   = tag;
        fpu_rsp_data  = fpu_rsp_data + 16'h0101;
    endtask

    // Monitor: every issue or response the DUT presents must match the next expectation.
    always @(negedge clk) begin
        iss_t ei;
        rsp_t er;
        logic [3:0] one;
        one = 4'b0001;
        if (!rst) begin
            if (fpu_valid && fpu_ready) begin
                if (iss_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL issue_unexpected: got tag %0d expected no issue at %0t", fpu_tag, $time);
                end else begin
                    ei = iss_q.pop_front();
                    chk("issue_tag", 32'(fpu_tag), 32'(ei.tag));
                    chk("issue_data", 32'(fpu_data), 32'(ei.data));
                    chk("issue_req_ready", 32'(req_ready), 32'(one << ei.tag));
                end
            end
            if (rsp_valid != '0) begin
                if (rsp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rsp_unexpected: got rsp_valid %0b expected none at %0t", rsp_valid, $time);
                end else begin
                    er = rsp_q.pop_front();
                    chk("rsp_valid_vec", 32'(rsp_valid), 32'(er.vec));
                    chk("rsp_data", 32'(rsp_data), 32'(er.data));
                    chk("rsp_fpu_ready", 32'(fpu_rsp_ready), 32'(er.rdy));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        req_valid     = 4'b1111;
        fpu_ready     = 1'b1;
        fpu_rsp_valid = 1'b1;
        fpu_rsp_tag   = 2'd1;
        fpu_rsp_data  = 16'h5000;
        rsp_ready     = 4'b1111;
        for (int i = 0; i < int'(NumReq); i++) req_data[i] = data_t'(16'h1000 * (i + 1) + i);

        repeat (2) @(posedge clk);
        settle();
        chk("rst_fpu_valid", 32'(fpu_valid), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fpu_rsp_ready", 32'(fpu_rsp_ready), 0);

        tick(); rst = 1'b0; req_valid = '0; fpu_rsp_valid = 1'b0;
        settle();
        chk("idle_fpu_valid", 32'(fpu_valid), 0);

        // Round robin between requesters 0 and 2.
        tick(); req_valid = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            if (k != 0) tick();
            push_iss((k % 2 == 0) ? 2'd0 : 2'd2);
            settle();
        end
        tick(); req_valid = '0;
        settle();
        chk("rr_busy", 32'(busy), 1);
        for (int k = 0; k < 4; k++) begin
            tick(); drive_rsp((k < 2) ? 2'd0 : 2'd2); push_rsp(1'b1);
            settle();
        end
        tick(); fpu_rsp_valid = 1'b0;
        settle();
        chk("rr_drained_busy", 32'(busy), 0);

        // Credit exhaustion on requester 1.
        for (int k = 0; k < int'(MaxOut); k++) begin
            tick(); req_valid = 4'b0010; push_iss(2'd1);
            settle();
        end
        tick();
        settle();
        chk("credit_out_valid", 32'(fpu_valid), 0);
        chk("credit_out_ready", 32'(req_ready), 0);
        tick(); drive_rsp(2'd1); push_rsp(1'b1);
        settle();
        chk("credit_not_same_cycle", 32'(fpu_valid), 0);
        tick(); fpu_rsp_valid = 1'b0; push_iss(2'd1);
        settle();
        tick(); req_valid = '0;
        settle();

        // Same-cycle issue and response for requester 1 at count 1.
        for (int k = 0; k < 2; k++) begin
            tick(); drive_rsp(2'd1); push_rsp(1'b1);
            settle();
        end
        tick(); req_valid = 4'b0010; drive_rsp(2'd1); push_iss(2'd1); push_rsp(1'b1);
        settle();
        tick(); req_valid = '0; fpu_rsp_valid = 1'b0;
        settle();
        chk("simul_cnt_nonzero", 32'(busy), 1);
        tick(); drive_rsp(2'd1); push_rsp(1'b1);
        settle();
        tick(); fpu_rsp_valid = 1'b0;
        settle();
        chk("simul_cnt_was_one", 32'(busy), 0);

        // Lock: requester 3 held while fpu_ready is low and requester 0 appears.
        tick(); flush = 1'b1;
        settle();
        tick(); flush = 1'b0;
        settle();
        tick(); req_valid = 4'b1000; fpu_ready = 1'b0; req_data[3] = 16'hC0DE;
        for (int k = 0; k < 3; k++) begin
            if (k != 0) begin
                tick(); req_valid = 4'b1001;
            end
            settle();
            chk("lock_valid", 32'(fpu_valid), 1);
            chk("lock_tag", 32'(fpu_tag), 3);
            chk("lock_data", 32'(fpu_data), 32'h0000C0DE);
            chk("lock_req_ready", 32'(req_ready), 0);
        end
        tick(); fpu_ready = 1'b1; push_iss(2'd3);
        settle();
        tick(); req_valid = 4'b0001; push_iss(2'd0);
        settle();
        tick(); req_valid = '0;
        settle();

        // Fill requester 2, then out-of-order responses with tag 2 stalled.
        tick(); req_valid = 4'b0100;
        for (int k = 0; k < int'(MaxOut); k++) begin
            if (k != 0) tick();
            push_iss(2'd2);
            settle();
        end
        for (int k = 0; k < 2; k++) begin
            tick(); drive_rsp(2'd2); rsp_ready = 4'b1011; push_rsp(1'b0);
            settle();
            chk("ooo_stall_no_credit", 32'(fpu_valid), 0);
        end
        tick(); rsp_ready = 4'b1111; drive_rsp(2'd2); push_rsp(1'b1);
        settle();
        chk("ooo_hs_credit_next", 32'(fpu_valid), 0);
        tick(); drive_rsp(2'd0); push_rsp(1'b1); push_iss(2'd2);
        settle();
        tick(); fpu_rsp_valid = 1'b0; req_valid = '0;
        settle();
        chk("ooo_busy", 32'(busy), 1);

        // Build counters {2,1,0,3}, leaving the round-robin pointer at 2.
        for (int k = 0; k < 3; k++) begin
            tick(); drive_rsp(2'd2); push_rsp(1'b1);
            settle();
        end
        tick(); fpu_rsp_valid = 1'b0; req_valid = 4'b1000; push_iss(2'd3);
        settle();
        tick(); push_iss(2'd3);
        settle();
        tick(); req_valid = 4'b0001; push_iss(2'd0);
        settle();
        tick(); push_iss(2'd0);
        settle();
        tick(); req_valid = 4'b0010; push_iss(2'd1);
        settle();
        tick(); req_valid = 4'b1000;
        settle();
        chk("pre_flush_full3", 32'(fpu_valid), 0);

        tick(); flush = 1'b1; req_valid = 4'b1111; drive_rsp(2'd0); rsp_ready = '0;
        settle();
        chk("flush_fpu_valid", 32'(fpu_valid), 0);
        chk("flush_req_ready", 32'(req_ready), 0);
        chk("flush_rsp_valid", 32'(rsp_valid), 0);
        chk("flush_fpu_rsp_ready", 32'(fpu_rsp_ready), 1);
        tick(); flush = 1'b0; req_valid = '0; fpu_rsp_valid = 1'b0; rsp_ready = 4'b1111;
        settle();
        chk("post_flush_busy", 32'(busy), 0);
        tick(); req_valid = 4'b1010; push_iss(2'd1);
        settle();
        tick(); req_valid = 4'b1000; push_iss(2'd3);
        settle();
        tick(); req_valid = '0;
        settle();

        chk("iss_q_drained", 32'(iss_q.size()), 0);
        chk("rsp_q_drained", 32'(rsp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
